// File: rtl/pcs_align_pkg.sv
// Purpose: shared types and default constants for the 10GBASE-R RX alignment logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcs_align_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_t;

    localparam int DEF_SETTLE_BEATS = 4;
    localparam int DEF_MAX_SLIPS    = 66;
    localparam int DEF_FAIL_HOLD    = 16;

endpackage

// File: rtl/rx_align_ctrl.sv
// Purpose: turns lock-FSM slip requests into rate-limited gearbox slips, holds lock FSM in reset while settling, escalates failed sweeps.
// Latency: slip request -> gearbox slip 1 cycle; lock change -> o_aligned 1 cycle; all outputs from registered state/counters.
// Backpressure: none; slip requests outside HUNT are dropped, SETTLE only advances on valid gearbox beats.
module rx_align_ctrl
    import pcs_align_pkg::*;
#(
    parameter int SETTLE_BEATS = DEF_SETTLE_BEATS,
    parameter int MAX_SLIPS    = DEF_MAX_SLIPS,
    parameter int FAIL_HOLD    = DEF_FAIL_HOLD
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_valid,
    input  logic                             i_slip_req,
    input  logic                             i_block_lock,
    output logic                             o_gearbox_slip,
    output logic                             o_lock_reset,
    output logic                             o_aligned,
    output logic                             o_xcvr_reset_req,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   o_slip_count,
    output logic [7:0]                       o_lock_loss_count
);

    localparam int SW = $clog2(MAX_SLIPS + 1);

    // Terminal values, sized once so comparisons stay width-clean.
    localparam logic [SW-1:0] SLIP_LAST = SW'(MAX_SLIPS - 1);
    localparam logic [7:0]    BEAT_LAST = 8'(SETTLE_BEATS - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(FAIL_HOLD - 1);

    align_state_t    state_q, state_d;
    logic [SW-1:0]   slip_cnt_q;
    logic [7:0]      beat_cnt_q;
    logic [7:0]      hold_cnt_q;
    logic [7:0]      loss_cnt_q;

    // State register; reset lands in INIT so the lock FSM starts held in reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a slip request in HUNT takes priority over lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_HUNT;
            ST_HUNT: begin
                if (i_slip_req) begin
                    // The last position of the sweep has been tried: escalate instead of slipping.
                    state_d = (slip_cnt_q == SLIP_LAST) ? ST_FAIL : ST_SLIP;
                end else if (i_block_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_SLIP:   state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (i_valid && (beat_cnt_q == BEAT_LAST)) begin
                    state_d = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (!i_block_lock) begin
                    state_d = ST_HUNT;
                end
            end
            ST_FAIL: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_HUNT;
                end
            end
            default:   state_d = ST_INIT;
        endcase
    end

    // Slip, settle-beat, fail-hold and lock-loss counters, all keyed off the registered state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slip_cnt_q <= '0;
            beat_cnt_q <= '0;
            hold_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_SLIP: begin
                    slip_cnt_q <= slip_cnt_q + 1'b1;
                end
                ST_SETTLE: begin
                    if (i_valid) begin
                        beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? 8'd0 : beat_cnt_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!i_block_lock) begin
                        // A fresh acquisition attempt starts with a full sweep budget.
                        slip_cnt_q <= '0;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_q <= loss_cnt_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q <= '0;
                        slip_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign o_gearbox_slip    = (state_q == ST_SLIP);
    assign o_lock_reset      = (state_q == ST_INIT) || (state_q == ST_SLIP) ||
                               (state_q == ST_SETTLE) || (state_q == ST_FAIL);
    assign o_aligned         = (state_q == ST_LOCKED);
    assign o_xcvr_reset_req  = (state_q == ST_FAIL);
    assign o_slip_count      = slip_cnt_q;
    assign o_lock_loss_count = loss_cnt_q;

endmodule
